// File: rtl/daq_mode_pkg.sv
// Shared types and SC configuration packing for the DAQ mode switch.
package daq_mode_pkg;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    CFG_WAIT = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  localparam int CTEST_W   = 64;
  localparam int DAC_W     = 10;
  localparam int MASK_W    = 192;
  localparam int CTEST_LSB = 0;
  localparam int DAC0_LSB  = CTEST_LSB + CTEST_W;
  localparam int DAC1_LSB  = DAC0_LSB + DAC_W;
  localparam int DAC2_LSB  = DAC1_LSB + DAC_W;
  localparam int MASK_LSB  = DAC2_LSB + DAC_W;
  localparam int SC_CFG_W  = MASK_LSB + MASK_W;

  // Every channel unmasked, CTest and DACs at zero.
  localparam logic [SC_CFG_W-1:0] SC_CFG_RST = {{MASK_W{1'b1}}, {MASK_LSB{1'b0}}};

  function automatic logic [SC_CFG_W-1:0] sc_cfg_pack(
    input logic [CTEST_W-1:0] ctest,
    input logic [DAC_W-1:0]   dac0,
    input logic [DAC_W-1:0]   dac1,
    input logic [DAC_W-1:0]   dac2,
    input logic [MASK_W-1:0]  mask
  );
    logic [SC_CFG_W-1:0] v;
    v = '0;
    v[CTEST_LSB +: CTEST_W] = ctest;
    v[DAC0_LSB  +: DAC_W]   = dac0;
    v[DAC1_LSB  +: DAC_W]   = dac1;
    v[DAC2_LSB  +: DAC_W]   = dac2;
    v[MASK_LSB  +: MASK_W]  = mask;
    return v;
  endfunction

endpackage

// File: rtl/daq_mode_drain_guard.sv
// Idle-cycle guard: o_done fires on the GUARD-th consecutive idle enabled cycle.
module daq_mode_drain_guard #(
  parameter int GUARD = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_done
);

  localparam int CW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [CW-1:0] LAST = CW'(GUARD - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en || i_clr) r_cnt <= '0;
    else if (r_cnt != LAST)         r_cnt <= r_cnt + 1'b1;
  end

  assign o_done = i_en & ~i_clr & (r_cnt == LAST);

endmodule

// File: rtl/daq_mode_switch.sv
// DAQ source switch: routes one of NUM_SRC sources, switching only after drain + SC reload.
// Optional DAQ_MODE_WORD_COUNT_EN adds a saturating accepted-word counter output.
module daq_mode_switch
  import daq_mode_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int DATA_W      = 16,
  parameter int CFG_W       = 286,
  parameter int GUARD       = 16,
  parameter int CFG_TIMEOUT = 65535,
  localparam int MW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      Clk,
  input  logic                      reset_n,
  input  logic [MW-1:0]             mode_req,
  output logic [MW-1:0]             mode_cur,
  output logic                      switch_busy,
  input  logic [NUM_SRC-1:0]        src_start_stop,
  output logic                      out_start_stop,
  input  logic [NUM_SRC*DATA_W-1:0] src_fifo_din,
  input  logic [NUM_SRC-1:0]        src_fifo_wr_en,
  input  logic                      usb_fifo_full,
  output logic [DATA_W-1:0]         out_fifo_din,
  output logic                      out_fifo_wr_en,
  output logic                      overflow,
  input  logic [NUM_SRC*CFG_W-1:0]  src_sc_cfg,
  output logic [CFG_W-1:0]          out_sc_cfg,
  input  logic [NUM_SRC-1:0]        src_sc_load,
  output logic                      out_sc_load,
  input  logic                      sc_config_done,
  output logic                      cfg_timeout,
  input  logic                      nPKTEND,
`ifdef DAQ_MODE_WORD_COUNT_EN
  output logic [31:0]               word_count,
`endif
  output logic                      data_transmit_done
);

  localparam int TW = $clog2(CFG_TIMEOUT + 1);
  localparam logic [TW-1:0]    TO_LAST = TW'(CFG_TIMEOUT - 1);
  localparam logic [MW:0]      NSRC    = (MW + 1)'(NUM_SRC);
  localparam logic [CFG_W-1:0] CFG_RST = CFG_W'(SC_CFG_RST);

  state_t              r_state, w_state_nxt;
  logic [MW-1:0]       r_mode, w_mode_nxt;
  logic [TW-1:0]       r_to_cnt;
  logic                r_ss, r_we, r_ld, r_ovf, r_to;
  logic [DATA_W-1:0]   r_din;
  logic [CFG_W-1:0]    r_cfg;
  logic                r_pkt, r_pkt_d, r_tx_done;

  logic                w_sel_ss, w_sel_we, w_sel_ld;
  logic [DATA_W-1:0]   w_sel_din;
  logic [CFG_W-1:0]    w_sel_cfg;
  logic                w_req_ok, w_act, w_guard_done, w_cfg_expire;
  logic                w_ss_d, w_ld_d, w_fwd, w_cfg_ld, w_we_d, w_drop;

  assign w_sel_ss  = src_start_stop[r_mode];
  assign w_sel_we  = src_fifo_wr_en[r_mode];
  assign w_sel_ld  = src_sc_load[r_mode];
  assign w_sel_din = src_fifo_din[r_mode*DATA_W +: DATA_W];
  assign w_sel_cfg = src_sc_cfg[r_mode*CFG_W +: CFG_W];

  // Out-of-range requests never start a switch.
  assign w_req_ok     = ({1'b0, mode_req} < NSRC) && (mode_req != r_mode);
  assign w_act        = w_sel_we | w_sel_ss;
  assign w_cfg_expire = (r_to_cnt == TO_LAST);

  daq_mode_drain_guard #(.GUARD(GUARD)) u_guard (
    .i_clk   (Clk),
    .i_rst_n (reset_n),
    .i_en    (r_state == DRAIN),
    .i_clr   (w_act),
    .o_done  (w_guard_done)
  );

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_state <= LOAD;
      r_mode  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_ss_d      = 1'b0;
    w_ld_d      = 1'b0;
    w_fwd       = 1'b0;
    w_cfg_ld    = 1'b0;
    case (r_state)
      LOAD: begin
        w_ld_d      = 1'b1;
        w_cfg_ld    = 1'b1;
        w_state_nxt = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (sc_config_done || w_cfg_expire) w_state_nxt = RUN;
      end
      RUN: begin
        w_ss_d   = w_sel_ss;
        w_ld_d   = w_sel_ld;
        w_fwd    = 1'b1;
        w_cfg_ld = 1'b1;
        if (w_req_ok) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_fwd = 1'b1;
        if (mode_req == r_mode) w_state_nxt = RUN;
        else if (w_guard_done && w_req_ok) begin
          w_state_nxt = LOAD;
          w_mode_nxt  = mode_req;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
    w_we_d = w_fwd & w_sel_we & ~usb_fifo_full;
    w_drop = w_fwd & w_sel_we & usb_fifo_full;
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_ss     <= 1'b0;
      r_we     <= 1'b0;
      r_ld     <= 1'b0;
      r_din    <= '0;
      r_cfg    <= CFG_RST;
      r_ovf    <= 1'b0;
      r_to     <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_ss <= w_ss_d;
      r_we <= w_we_d;
      r_ld <= w_ld_d;
      if (w_fwd)    r_din <= w_sel_din;
      if (w_cfg_ld) r_cfg <= w_sel_cfg;
      if (w_drop)   r_ovf <= 1'b1;
      if (r_state == CFG_WAIT) begin
        r_to_cnt <= r_to_cnt + 1'b1;
        // A done pulse landing on the expiry cycle still counts as success.
        if (w_cfg_expire && !sc_config_done) r_to <= 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_pkt     <= 1'b0;
      r_pkt_d   <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_pkt     <= nPKTEND;
      r_pkt_d   <= r_pkt;
      r_tx_done <= r_pkt_d & ~r_pkt;
    end
  end

`ifdef DAQ_MODE_WORD_COUNT_EN
  logic [31:0] r_wcnt;
  always_ff @(posedge Clk) begin
    if (!reset_n || (r_state != RUN && w_state_nxt == RUN)) r_wcnt <= '0;
    else if (r_we && r_wcnt != 32'hFFFF_FFFF)               r_wcnt <= r_wcnt + 1'b1;
  end
  assign word_count = r_wcnt;
`endif

  assign mode_cur           = r_mode;
  assign switch_busy        = (r_state != RUN);
  assign out_start_stop     = r_ss;
  assign out_fifo_wr_en     = r_we;
  assign out_fifo_din       = r_din;
  assign overflow           = r_ovf;
  assign out_sc_cfg         = r_cfg;
  assign out_sc_load        = r_ld;
  assign cfg_timeout        = r_to;
  assign data_transmit_done = r_tx_done;

endmodule
